// File: rtl/host_req_queue_pkg.sv
// Shared encodings for the host request queue: FSM states, command op codes
// and the SDRAM data width.
package host_req_queue_pkg;
   localparam int SDRAM_DW = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_CAPTURE   = 3'd4
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;
endpackage

// File: rtl/host_req_queue_fifo.sv
// Synchronous first-word-fall-through FIFO; push when full and pop when
// empty are ignored so callers may drive the strobes unconditionally.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic [WIDTH-1:0]      i_din,
   input  logic                  i_pop,
   output logic [WIDTH-1:0]      o_dout,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DEPTH_LOG2:0]   o_level
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_level;
   logic                  w_do_push;
   logic                  w_do_pop;

   assign o_full    = (r_level == FULL_LVL);
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + (DEPTH_LOG2+1)'(1);
            2'b01:   r_level <= r_level - (DEPTH_LOG2+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end
endmodule

// File: rtl/host_req_queue.sv
// Host request queue: buffers host read/write requests and issues them one at
// a time to the SDRAM controller, capturing read data and flagging faults.
module host_req_queue
   import host_req_queue_pkg::*;
#(
   parameter int HADDR_WIDTH = 24,
   parameter int DEPTH_LOG2  = 2,
   parameter int BUSY_TMO    = 7
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [HADDR_WIDTH-1:0] h_addr,
   input  logic [SDRAM_DW-1:0]    h_wdata,
   input  logic                   h_rd_req,
   input  logic                   h_wr_req,
   output logic                   h_full,
   output logic [DEPTH_LOG2:0]    h_level,
   output logic [SDRAM_DW-1:0]    h_rdata,
   output logic                   h_rvalid,
   output logic                   h_ovf,
   output logic                   h_err,
   output logic [HADDR_WIDTH-1:0] c_addr,
   output logic [SDRAM_DW-1:0]    c_wdata,
   output logic                   c_rd_enable,
   output logic                   c_wr_enable,
   input  logic                   c_busy,
   input  logic [SDRAM_DW-1:0]    c_rdata
);
   localparam int ENTRY_W = 1 + HADDR_WIDTH + SDRAM_DW;
   localparam int TMO_W   = $clog2(BUSY_TMO + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

   state_t                 r_state;
   state_t                 w_next_state;
   op_t                    r_op;
   logic [HADDR_WIDTH-1:0] r_cmd_addr;
   logic [SDRAM_DW-1:0]    r_cmd_wdata;
   logic [SDRAM_DW-1:0]    r_rdata;
   logic                   r_rvalid;
   logic                   r_ovf;
   logic                   r_err;
   logic [TMO_W-1:0]       r_tmo_cnt;

   op_t                    w_req_op;
   logic                   w_req_any;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_timeout;
   logic                   w_capture;
   logic                   w_full;
   logic                   w_empty;
   logic [DEPTH_LOG2:0]    w_level;
   logic [ENTRY_W-1:0]     w_din;
   logic [ENTRY_W-1:0]     w_dout;

   // A simultaneous read+write request collapses into the write.
   assign w_req_any = h_rd_req | h_wr_req;
   assign w_req_op  = h_wr_req ? OP_WR : OP_RD;
   assign w_push    = w_req_any & ~w_full;
   assign w_din     = {w_req_op, h_addr, h_wdata};

   sync_fifo #(
      .WIDTH      (ENTRY_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_din   (w_din),
      .i_pop   (w_pop),
      .o_dout  (w_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:      if (!w_empty && !c_busy) w_next_state = ST_ISSUE;
         ST_ISSUE:     w_next_state = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (c_busy)                      w_next_state = ST_WAIT_DONE;
            else if (r_tmo_cnt == TMO_LAST)  w_next_state = ST_IDLE;
         end
         ST_WAIT_DONE: if (!c_busy) w_next_state = (r_op == OP_WR) ? ST_IDLE : ST_CAPTURE;
         ST_CAPTURE:   w_next_state = ST_IDLE;
         default:      w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_pop       = (r_state == ST_IDLE) && (w_next_state == ST_ISSUE);
      w_timeout   = (r_state == ST_WAIT_BUSY) && !c_busy && (r_tmo_cnt == TMO_LAST);
      w_capture   = (r_state == ST_CAPTURE);
      c_rd_enable = (r_state == ST_ISSUE) && (r_op == OP_RD);
      c_wr_enable = (r_state == ST_ISSUE) && (r_op == OP_WR);
   end

   // Command registers load only on the pop edge, so they stay stable between issues.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op        <= OP_RD;
         r_cmd_addr  <= '0;
         r_cmd_wdata <= '0;
         r_tmo_cnt   <= '0;
         r_rdata     <= '0;
         r_rvalid    <= 1'b0;
         r_ovf       <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (w_pop) begin
            r_op        <= op_t'(w_dout[ENTRY_W-1]);
            r_cmd_addr  <= w_dout[ENTRY_W-2 -: HADDR_WIDTH];
            r_cmd_wdata <= w_dout[SDRAM_DW-1:0];
         end
         if (r_state == ST_WAIT_BUSY) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
         else                         r_tmo_cnt <= '0;
         if (w_capture) r_rdata <= c_rdata;
         r_rvalid <= w_capture;
         if (w_req_any && w_full) r_ovf <= 1'b1;
         if (w_timeout)           r_err <= 1'b1;
      end
   end

   assign h_full   = w_full;
   assign h_level  = w_level;
   assign h_rdata  = r_rdata;
   assign h_rvalid = r_rvalid;
   assign h_ovf    = r_ovf;
   assign h_err    = r_err;
   assign c_addr   = r_cmd_addr;
   assign c_wdata  = r_cmd_wdata;
endmodule

// File: tb/tb_host_req_queue.sv
// Directed self-checking bench for host_req_queue with a small scripted
// SDRAM controller that can be switched between manual and auto-respond.
module tb_host_req_queue;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] h_addr = '0;
   logic [15:0] h_wdata = '0;
   logic        h_rd_req = 1'b0;
   logic        h_wr_req = 1'b0;
   logic        h_full;
   logic [2:0]  h_level;
   logic [15:0] h_rdata;
   logic        h_rvalid;
   logic        h_ovf;
   logic        h_err;
   logic [23:0] c_addr;
   logic [15:0] c_wdata;
   logic        c_rd_enable;
   logic        c_wr_enable;
   logic        c_busy;
   logic [15:0] c_rdata = '0;

   logic        man_busy = 1'b0;
   logic        auto_ctl = 1'b0;
   int          auto_cnt = 0;
   int          wr_strobes = 0;
   int          rd_strobes = 0;
   int          rv_pulses = 0;
   int          total = 0;
   int          bad = 0;
   int          wr0, rd0, rv0;

   host_req_queue dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .h_addr      (h_addr),
      .h_wdata     (h_wdata),
      .h_rd_req    (h_rd_req),
      .h_wr_req    (h_wr_req),
      .h_full      (h_full),
      .h_level     (h_level),
      .h_rdata     (h_rdata),
      .h_rvalid    (h_rvalid),
      .h_ovf       (h_ovf),
      .h_err       (h_err),
      .c_addr      (c_addr),
      .c_wdata     (c_wdata),
      .c_rd_enable (c_rd_enable),
      .c_wr_enable (c_wr_enable),
      .c_busy      (c_busy),
      .c_rdata     (c_rdata)
   );

   always #5 clk = ~clk;

   // Auto controller: busy rises the half-cycle after a strobe, for three negedges.
   assign c_busy = auto_ctl ? (auto_cnt != 0) : man_busy;

   always @(negedge clk) begin
      if (c_rd_enable || c_wr_enable) auto_cnt <= 3;
      else if (auto_cnt != 0)         auto_cnt <= auto_cnt - 1;
      if (c_wr_enable) wr_strobes <= wr_strobes + 1;
      if (c_rd_enable) rd_strobes <= rd_strobes + 1;
      if (h_rvalid)    rv_pulses  <= rv_pulses + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_level", 32'(h_level), 0);
      check("rst_full", 32'(h_full), 0);
      check("rst_rvalid", 32'(h_rvalid), 0);
      check("rst_ovf", 32'(h_ovf), 0);
      check("rst_err", 32'(h_err), 0);
      check("rst_strobes", 32'({c_rd_enable, c_wr_enable}), 0);
      check("rst_caddr", 32'(c_addr), 0);
      check("rst_rdata", 32'(h_rdata), 0);
      rst_n = 1'b1;
      tick();

      // Single write, busy rises three cycles after the strobe
      h_addr = 24'h000010; h_wdata = 16'hA5A5; h_wr_req = 1'b1;
      tick();
      h_wr_req = 1'b0;
      check("wr_level_push", 32'(h_level), 1);
      check("wr_no_strobe_yet", 32'(c_wr_enable), 0);
      tick();
      check("wr_strobe", 32'(c_wr_enable), 1);
      check("wr_no_rd_strobe", 32'(c_rd_enable), 0);
      check("wr_caddr", 32'(c_addr), 32'h10);
      check("wr_cwdata", 32'(c_wdata), 32'hA5A5);
      check("wr_level_pop", 32'(h_level), 0);
      tick();
      check("wr_strobe_one_cycle", 32'(c_wr_enable), 0);
      tick();
      tick();
      man_busy = 1'b1;
      tick();
      tick();
      tick();
      man_busy = 1'b0;
      tick();
      tick();
      check("wr_no_rvalid", 32'(rv_pulses), 0);
      check("wr_no_err", 32'(h_err), 0);
      check("wr_strobe_count", 32'(wr_strobes), 1);
      check("wr_caddr_hold", 32'(c_addr), 32'h10);

      // Single read returning 0x5A5A
      h_addr = 24'h000010; h_rd_req = 1'b1;
      tick();
      h_rd_req = 1'b0;
      tick();
      check("rd_strobe", 32'(c_rd_enable), 1);
      check("rd_no_wr_strobe", 32'(c_wr_enable), 0);
      check("rd_caddr", 32'(c_addr), 32'h10);
      man_busy = 1'b1;
      tick();
      tick();
      man_busy = 1'b0; c_rdata = 16'h5A5A;
      tick();
      check("rd_rvalid_in_capture", 32'(h_rvalid), 0);
      tick();
      check("rd_rvalid", 32'(h_rvalid), 1);
      check("rd_rdata", 32'(h_rdata), 32'h5A5A);
      c_rdata = 16'h1111;
      tick();
      check("rd_rvalid_drop", 32'(h_rvalid), 0);
      check("rd_rdata_hold", 32'(h_rdata), 32'h5A5A);
      check("rd_rvalid_count", 32'(rv_pulses), 1);

      // Five writes with the controller busy: fourth fills, fifth overflows
      man_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         h_wr_req = 1'b1; h_addr = 24'h000100 + 24'(i); h_wdata = 16'(i);
         tick();
         if (i == 3) begin
            check("ovf_full_at_4", 32'(h_full), 1);
            check("ovf_not_yet", 32'(h_ovf), 0);
         end
      end
      h_wr_req = 1'b0;
      check("ovf_level", 32'(h_level), 4);
      check("ovf_full", 32'(h_full), 1);
      check("ovf_sticky", 32'(h_ovf), 1);
      wr0 = wr_strobes;
      man_busy = 1'b0; auto_ctl = 1'b1;
      repeat (40) tick();
      check("ovf_drain_count", 32'(wr_strobes - wr0), 4);
      check("ovf_last_addr", 32'(c_addr), 32'h103);
      check("ovf_last_wdata", 32'(c_wdata), 32'h3);
      check("ovf_drained", 32'(h_level), 0);
      check("ovf_still_set", 32'(h_ovf), 1);

      // Read and write in the same cycle enqueue one write
      wr0 = wr_strobes; rd0 = rd_strobes; rv0 = rv_pulses;
      h_addr = 24'h000020; h_wdata = 16'hBEEF; h_rd_req = 1'b1; h_wr_req = 1'b1;
      tick();
      h_rd_req = 1'b0; h_wr_req = 1'b0;
      check("both_level", 32'(h_level), 1);
      repeat (15) tick();
      check("both_wr_count", 32'(wr_strobes - wr0), 1);
      check("both_rd_count", 32'(rd_strobes - rd0), 0);
      check("both_rvalid", 32'(rv_pulses - rv0), 0);
      check("both_wdata", 32'(c_wdata), 32'hBEEF);

      // Push and pop on the same edge keep the level
      h_addr = 24'h000050; h_wr_req = 1'b1;
      tick();
      h_addr = 24'h000051;
      tick();
      h_wr_req = 1'b0;
      check("pushpop_level", 32'(h_level), 1);
      repeat (20) tick();
      check("pushpop_drained", 32'(h_level), 0);
      check("pushpop_last_addr", 32'(c_addr), 32'h51);

      // Busy never rises: timeout then the next entry issues
      auto_ctl = 1'b0; man_busy = 1'b0;
      h_addr = 24'h000030; h_wr_req = 1'b1;
      tick();
      h_addr = 24'h000031;
      tick();
      h_wr_req = 1'b0;
      check("tmo_strobe", 32'(c_wr_enable), 1);
      check("tmo_caddr", 32'(c_addr), 32'h30);
      repeat (7) tick();
      check("tmo_err_early", 32'(h_err), 0);
      tick();
      check("tmo_err", 32'(h_err), 1);
      check("tmo_idle_no_strobe", 32'(c_wr_enable), 0);
      tick();
      check("tmo_next_strobe", 32'(c_wr_enable), 1);
      check("tmo_next_addr", 32'(c_addr), 32'h31);
      repeat (12) tick();
      check("tmo_err_sticky", 32'(h_err), 1);

      // Reset during WAIT_DONE of a read with two entries queued
      h_addr = 24'h000040; h_rd_req = 1'b1;
      tick();
      h_rd_req = 1'b0; h_addr = 24'h000041; h_wdata = 16'h4141; h_wr_req = 1'b1;
      tick();
      check("rstmid_rd_strobe", 32'(c_rd_enable), 1);
      h_addr = 24'h000042; h_wdata = 16'h4242;
      tick();
      h_wr_req = 1'b0;
      check("rstmid_level", 32'(h_level), 2);
      man_busy = 1'b1; c_rdata = 16'h7777;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      check("rstmid_level0", 32'(h_level), 0);
      check("rstmid_full", 32'(h_full), 0);
      check("rstmid_ovf", 32'(h_ovf), 0);
      check("rstmid_err", 32'(h_err), 0);
      check("rstmid_rdata", 32'(h_rdata), 0);
      check("rstmid_rvalid", 32'(h_rvalid), 0);
      check("rstmid_caddr", 32'(c_addr), 0);
      check("rstmid_cwdata", 32'(c_wdata), 0);
      check("rstmid_strobes", 32'({c_rd_enable, c_wr_enable}), 0);
      man_busy = 1'b0;
      rst_n = 1'b1;
      wr0 = wr_strobes; rd0 = rd_strobes; rv0 = rv_pulses;
      repeat (15) tick();
      check("rstmid_no_wr", 32'(wr_strobes - wr0), 0);
      check("rstmid_no_rd", 32'(rd_strobes - rd0), 0);
      check("rstmid_no_rvalid", 32'(rv_pulses - rv0), 0);
      check("rstmid_level_after", 32'(h_level), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
